// File: rtl/shifter_seq_unit.sv
// Iterative 16-bit shift/rotate engine: one bit position per clock, 0-15 positions,
// start/busy/done handshake, result/carry/zero held until the next accepted start.
module shifter_seq_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dir,
    input  logic        arith,
    input  logic        rotate,
    input  logic [3:0]  count,
    input  logic [15:0] in_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] out_data,
    output logic        carry,
    output logic        zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef struct packed {
        logic dir;
        logic arith;
        logic rotate;
    } op_t;

    state_t      state, state_nxt;
    op_t         op_q;
    logic [3:0]  rem_q;
    logic        fill;
    logic [15:0] shifted;
    logic        shifted_carry;

    // Rotate wins over arith; arith only matters on right shifts.
    always_comb begin
        fill          = 1'b0;
        shifted       = out_data;
        shifted_carry = carry;
        if (op_q.dir) begin
            fill          = op_q.rotate ? out_data[0] : (op_q.arith & out_data[15]);
            shifted       = {fill, out_data[15:1]};
            shifted_carry = out_data[0];
        end else begin
            fill          = op_q.rotate & out_data[15];
            shifted       = {out_data[14:0], fill};
            shifted_carry = out_data[15];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (count != 4'd0) ? SHIFT : DONE;
            SHIFT:   if (rem_q == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            rem_q    <= '0;
            out_data <= '0;
            carry    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    op_q     <= '{dir: dir, arith: arith, rotate: rotate};
                    rem_q    <= count;
                    out_data <= in_data;
                    carry    <= 1'b0;
                end
                SHIFT: begin
                    out_data <= shifted;
                    carry    <= shifted_carry;
                    rem_q    <= rem_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign zero = (out_data == 16'h0000);

endmodule
